// File: rtl/noc_port_arbiter.sv
// Round-robin, packet-locked arbiter sharing one NoC injection port among NumReq requesters.
// Optional per-requester packet counters are enabled with NOC_PORT_ARBITER_STATS_EN.
//
// state  | meaning
// IDLE   | no packet in flight, round-robin search from rr_ptr
// LOCKED | mid-packet, only lock_idx may be granted until its last flit
module noc_port_arbiter #(
    parameter int NumReq    = 4,
    parameter int DataWidth = 64,
    parameter int IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1,
    parameter int CntWidth  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq*DataWidth-1:0]   req_data_i,
    input  logic [NumReq-1:0]             req_last_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DataWidth-1:0]          out_data_o,
    output logic                          out_last_o,
    output logic [IdxWidth-1:0]           out_idx_o,
    output logic                          busy_o,
    output logic [NumReq*CntWidth-1:0]    pkt_cnt_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [IdxWidth-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdxWidth-1:0]   lock_idx_q, lock_idx_d;
    logic                  out_valid_q, out_valid_d;
    logic [DataWidth-1:0]  out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic [IdxWidth-1:0]   out_idx_q, out_idx_d;

    logic                  free;
    logic                  grant_vld;
    logic [IdxWidth-1:0]   grant_idx;
    logic [IdxWidth-1:0]   cand_idx;
    logic                  accept;
    logic                  acc_last;

    assign free = !out_valid_q || out_ready_i;

    // Search descends so the candidate closest to rr_ptr is the one left standing.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        if (state_q == LOCKED) begin
            grant_vld = req_valid_i[lock_idx_q];
            grant_idx = lock_idx_q;
        end else begin
            for (int k = NumReq - 1; k >= 0; k--) begin
                cand_idx = IdxWidth'((int'(rr_ptr_q) + k) % NumReq);
                if (req_valid_i[cand_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand_idx;
                end
            end
        end
    end

    assign accept   = grant_vld && free;
    assign acc_last = req_last_i[grant_idx];

    always_comb begin
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_idx_d  = lock_idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_idx_d   = out_idx_q;
        if (free) begin
            out_valid_d = accept;
        end
        if (accept) begin
            out_data_d = req_data_i[grant_idx*DataWidth +: DataWidth];
            out_last_d = acc_last;
            out_idx_d  = grant_idx;
            if (acc_last) begin
                state_d  = IDLE;
                rr_ptr_d = (grant_idx == IdxWidth'(NumReq - 1)) ? '0 : grant_idx + 1'b1;
            end else if (state_q == IDLE) begin
                state_d    = LOCKED;
                lock_idx_d = grant_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            lock_idx_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_idx_q  <= lock_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign out_idx_o   = out_idx_q;
    assign busy_o      = (state_q == LOCKED) || out_valid_q;

`ifdef NOC_PORT_ARBITER_STATS_EN
    logic [NumReq-1:0][CntWidth-1:0] cnt_q, cnt_d;

    // Counters saturate rather than wrap so a stuck-high count is distinguishable.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && acc_last && (cnt_q[grant_idx] != '1)) begin
            cnt_d[grant_idx] = cnt_q[grant_idx] + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pkt_cnt_o = cnt_q;
`else
    assign pkt_cnt_o = '0;
`endif

endmodule
